// File: rtl/trigger_capture_ctrl_pkg.sv
// Shared types and constants for the trigger capture controller.
// Covers edge-select encodings, FSM state encoding and a forwarding-state helper.
package trigger_capture_ctrl_pkg;

  localparam logic TRIG_EDGE_RISING  = 1'b0;
  localparam logic TRIG_EDGE_FALLING = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // True in the states where accepted samples go downstream
  function automatic logic is_forwarding(input state_e s);
    return (s == ST_PRE) || (s == ST_WAIT) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/trigger_capture_ctrl_edge_detector.sv
// Level-crossing detector: remembers the previous accepted sample and flags
// whether the current sample crosses the level in the selected direction.
module trigger_edge_detector
  import trigger_capture_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic                  accept,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] level,
  input  logic                  trig_edge,
  output logic                  crossing
);

  logic [DATA_WIDTH-1:0] prev_q;
  logic                  prev_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else if (clear) begin
      prev_valid_q <= 1'b0;
    end else if (accept) begin
      prev_q       <= sample;
      prev_valid_q <= 1'b1;
    end
  end

  always_comb begin
    crossing = 1'b0;
    if (prev_valid_q) begin
      if (trig_edge == TRIG_EDGE_RISING)
        crossing = (prev_q < level) && (sample >= level);
      else
        crossing = (prev_q > level) && (sample <= level);
    end
  end

endmodule

// File: rtl/trigger_capture_ctrl.sv
// Frames one acquisition (pre-trigger count, level-crossing search, post-trigger
// count) from the ADC sample stream and forwards it with the trigger sample flagged.
module trigger_capture_ctrl
  import trigger_capture_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  SI_data_i,
  input  logic                   SI_rdy_i,
  output logic                   SI_ack_o,
  output logic [DATA_WIDTH-1:0]  SI_data_o,
  output logic                   SI_trig_o,
  output logic                   SI_rdy_o,
  input  logic                   SI_ack_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   force_i,
  input  logic [DATA_WIDTH-1:0]  trig_level_i,
  input  logic                   trig_edge_i,
  input  logic [COUNT_WIDTH-1:0] pre_count_i,
  input  logic [COUNT_WIDTH-1:0] post_count_i,
  output logic                   busy_o,
  output logic                   done_o
);

  // Handshake: a sample moves when rdy and ack are both high in the same cycle.
  // Input ack is unconditional while idle/done; otherwise the one-entry output
  // register may accept when empty or when it is being drained this cycle.

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0] pre_q, post_q, post_eff;
  logic [DATA_WIDTH-1:0]  level_q;
  logic                   edge_q;
  logic                   force_q, force_d;
  logic                   start_go, trig_hit, accept, load, crossing;

  assign SI_ack_o = ((state_q == ST_IDLE) || (state_q == ST_DONE)) ? 1'b1
                                                                   : (~SI_rdy_o | SI_ack_i);
  assign accept   = SI_rdy_i & SI_ack_o;
  assign load     = accept & is_forwarding(state_q);
  assign post_eff = (post_q == '0) ? COUNT_WIDTH'(1) : post_q;
  assign busy_o   = is_forwarding(state_q);
  assign done_o   = (state_q == ST_DONE);

  trigger_edge_detector #(.DATA_WIDTH(DATA_WIDTH)) u_edge (
    .clk_i     (clk_i),
    .rst       (rst),
    .sample    (SI_data_i),
    .accept    (load),
    .clear     (start_go),
    .level     (level_q),
    .trig_edge (edge_q),
    .crossing  (crossing)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    force_d  = force_q;
    start_go = 1'b0;
    trig_hit = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          start_go = 1'b1;
          cnt_d    = '0;
          state_d  = (pre_count_i == '0) ? ST_WAIT : ST_PRE;
        end
      end
      ST_PRE: begin
        if (accept) begin
          if (cnt_q == pre_q - COUNT_WIDTH'(1)) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
          end
        end
      end
      ST_WAIT: begin
        if (force_i) force_d = 1'b1;
        // The trigger sample itself is post sample number one
        if (accept && (crossing || force_q || force_i)) begin
          trig_hit = 1'b1;
          cnt_d    = COUNT_WIDTH'(1);
          state_d  = (post_eff == COUNT_WIDTH'(1)) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (accept) begin
          if (cnt_q + COUNT_WIDTH'(1) == post_eff) state_d = ST_DONE;
          else cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      start_go = 1'b0;
      cnt_d    = '0;
    end
    if (state_d != ST_WAIT) force_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      force_q   <= 1'b0;
      pre_q     <= '0;
      post_q    <= '0;
      level_q   <= '0;
      edge_q    <= TRIG_EDGE_RISING;
      SI_data_o <= '0;
      SI_rdy_o  <= 1'b0;
      SI_trig_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      force_q <= force_d;
      if (start_go) begin
        pre_q   <= pre_count_i;
        post_q  <= post_count_i;
        level_q <= trig_level_i;
        edge_q  <= trig_edge_i;
      end
      // Output register drains in every state, so an abort never strands a sample
      if (load) begin
        SI_data_o <= SI_data_i;
        SI_rdy_o  <= 1'b1;
        SI_trig_o <= trig_hit;
      end else if (SI_ack_i) begin
        SI_rdy_o  <= 1'b0;
        SI_trig_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Bench for trigger_capture_ctrl: directed scenarios plus randomized acquisitions,
// checked against a frame-level reference model of the expected forwarded stream.
module tb_trigger_capture_ctrl;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] SI_data_i = '0;
  logic          SI_rdy_i = 1'b0;
  logic          SI_ack_o;
  logic [DW-1:0] SI_data_o;
  logic          SI_trig_o;
  logic          SI_rdy_o;
  logic          SI_ack_i = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          force_i = 1'b0;
  logic [DW-1:0] trig_level_i = '0;
  logic          trig_edge_i = 1'b0;
  logic [CW-1:0] pre_count_i = '0;
  logic [CW-1:0] post_count_i = '0;
  logic          busy_o;
  logic          done_o;

  int vectors = 0;
  int miscompares = 0;
  int ack_mode = 0;            // 0: always ack, 1: random ack, 2: hold ack low
  bit acq_open = 0;

  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] acc_q[$];     // samples the DUT accepted during the current acquisition
  logic [DW:0]   got_q[$];     // {trig, data} observed downstream
  logic [DW:0]   exp_q[$];

  trigger_capture_ctrl #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst(rst),
    .SI_data_i(SI_data_i), .SI_rdy_i(SI_rdy_i), .SI_ack_o(SI_ack_o),
    .SI_data_o(SI_data_o), .SI_trig_o(SI_trig_o), .SI_rdy_o(SI_rdy_o), .SI_ack_i(SI_ack_i),
    .start_i(start_i), .abort_i(abort_i), .force_i(force_i),
    .trig_level_i(trig_level_i), .trig_edge_i(trig_edge_i),
    .pre_count_i(pre_count_i), .post_count_i(post_count_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  // ---------------- clock / downstream ack / monitor ----------------
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #2;
    case (ack_mode)
      0:       SI_ack_i = 1'b1;
      1:       SI_ack_i = ($urandom_range(0, 3) != 0);
      default: SI_ack_i = 1'b0;
    endcase
  end

  always @(negedge clk_i) begin
    if (!rst && SI_rdy_o && SI_ack_i) got_q.push_back({SI_trig_o, SI_data_o});
  end

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (all start/end at posedge+1) ----------------
  task automatic cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit ok = 0;
    SI_rdy_i  = 1'b1;
    SI_data_i = d;
    for (int g = 0; g < 200 && !ok; g++) begin
      @(negedge clk_i);
      ok = SI_ack_o;
      @(posedge clk_i); #1;
    end
    SI_rdy_i = 1'b0;
    vectors++;
    assert (ok) else begin
      miscompares++;
      $error("FAIL send_timeout: observed ack %0d expected 1", ok);
    end
    if (ok && acq_open) acc_q.push_back(d);
  endtask

  task automatic send_all();
    while (stim_q.size() > 0) send(stim_q.pop_front());
  endtask

  task automatic pulse_force();
    force_i = 1'b1; cycle(); force_i = 1'b0;
  endtask

  task automatic pulse_abort();
    abort_i = 1'b1; cycle(); abort_i = 1'b0;
    acq_open = 0;
  endtask

  task automatic start_acq(input int pre, input int post, input logic [DW-1:0] lvl, input logic edg);
    acc_q.delete();
    got_q.delete();
    trig_level_i = lvl;
    trig_edge_i  = edg;
    pre_count_i  = CW'(pre);
    post_count_i = CW'(post);
    start_i = 1'b1; cycle(); start_i = 1'b0;
    acq_open = 1;
    // Scramble config so any failure to latch shows up in the frame
    trig_level_i = DW'($urandom);
    trig_edge_i  = 1'($urandom);
    pre_count_i  = CW'($urandom_range(0, 9));
    post_count_i = CW'($urandom_range(0, 9));
  endtask

  task automatic drain();
    bit empty = 0;
    ack_mode = 0;
    for (int g = 0; g < 30 && !empty; g++) begin
      @(negedge clk_i);
      empty = !SI_rdy_o;
      cycle();
    end
    chk("drain_empty", {31'd0, SI_rdy_o}, 32'd0);
  endtask

  // ---------------- reference model ----------------
  function automatic bit crosses(input logic [DW-1:0] p, input logic [DW-1:0] s,
                                 input logic [DW-1:0] lvl, input logic edg);
    if (edg == 1'b0) return (p < lvl) && (s >= lvl);
    return (p > lvl) && (s <= lvl);
  endfunction

  // Frame = first pre accepted samples, search from there for the first crossing
  // (or the forced index), trigger sample opens a window of max(post,1) samples.
  function automatic bit build_exp(input int pre, input int post, input logic [DW-1:0] lvl,
                                   input logic edg, input int force_idx);
    int post_eff = (post == 0) ? 1 : post;
    int t = -1;
    int n;
    exp_q.delete();
    for (int i = pre; i < acc_q.size(); i++) begin
      if ((force_idx >= 0 && i >= force_idx) || (i > 0 && crosses(acc_q[i-1], acc_q[i], lvl, edg))) begin
        t = i;
        break;
      end
    end
    n = (t < 0) ? acc_q.size() : t + post_eff;
    if (n > acc_q.size()) n = acc_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back({(i == t), acc_q[i]});
    return (t >= 0) && (t + post_eff <= acc_q.size());
  endfunction

  task automatic finish_acq(input string tag, input int pre, input int post, input logic [DW-1:0] lvl,
                            input logic edg, input int force_idx, input bit aborted);
    bit exp_done;
    drain();
    exp_done = build_exp(pre, post, lvl, edg, force_idx) && !aborted;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_item%0d", tag, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    chk({tag, "_done"}, {31'd0, done_o}, {31'd0, exp_done});
    chk({tag, "_busy"}, {31'd0, busy_o}, {31'd0, !exp_done && !aborted});
    if (!exp_done && !aborted) begin
      pulse_abort();
      chk({tag, "_abort_busy"}, {31'd0, busy_o}, 32'd0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    repeat (3) cycle();
    chk("rst_rdy", {31'd0, SI_rdy_o}, 32'd0);
    chk("rst_trig", {31'd0, SI_trig_o}, 32'd0);
    chk("rst_data", {24'd0, SI_data_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    rst = 1'b0;
    cycle();
    chk("idle_ack", {31'd0, SI_ack_o}, 32'd1);

    // 1: rising crossing after pre window, trailing samples discarded
    ack_mode = 1;
    start_acq(4, 3, 8'h80, 1'b0);
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    stim_q = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    send_all();
    finish_acq("t1", 4, 3, 8'h80, 1'b0, -1, 0);
    chk("t1_discard_ack", {31'd0, SI_ack_o}, 32'd1);

    // 2: falling, pre=0 post=1; then a flat stream that must never trigger
    ack_mode = 0;
    start_acq(0, 1, 8'h40, 1'b1);
    stim_q = '{8'h50, 8'h40, 8'h30};
    send_all();
    finish_acq("t2a", 0, 1, 8'h40, 1'b1, -1, 0);
    start_acq(0, 1, 8'h40, 1'b1);
    for (int i = 0; i < 8; i++) stim_q.push_back(8'h40);
    send_all();
    finish_acq("t2b", 0, 1, 8'h40, 1'b1, -1, 0);

    // 3: downstream stall during POST
    ack_mode = 0;
    start_acq(2, 6, 8'h80, 1'b0);
    stim_q = '{8'h10, 8'h20, 8'h30, 8'h90, 8'hA0, 8'hB0};
    send_all();
    ack_mode  = 2;
    SI_rdy_i  = 1'b1;
    SI_data_i = 8'hC0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk($sformatf("t3_stall_ack%0d", i), {31'd0, SI_ack_o}, 32'd0);
      cycle();
    end
    SI_rdy_i = 1'b0;
    ack_mode = 0;
    stim_q = '{8'hC0, 8'hD0, 8'hE0, 8'hF0};
    send_all();
    finish_acq("t3", 2, 6, 8'h80, 1'b0, -1, 0);

    // 4: force in IDLE ignored, force in WAIT flags the next accepted sample
    pulse_force();
    start_acq(0, 2, 8'h80, 1'b0);
    for (int i = 0; i < 3; i++) send(8'h00);
    pulse_force();
    for (int i = 0; i < 4; i++) send(8'h00);
    finish_acq("t4", 0, 2, 8'h80, 1'b0, 3, 0);

    // 5: abort in POST while a sample is held downstream
    ack_mode = 0;
    start_acq(1, 8, 8'h80, 1'b0);
    stim_q = '{8'h00, 8'h10, 8'h90, 8'hA0};
    send_all();
    ack_mode = 2;
    pulse_abort();
    chk("t5_busy", {31'd0, busy_o}, 32'd0);
    chk("t5_pending", {31'd0, SI_rdy_o}, 32'd1);
    send(8'hB0);
    send(8'hC0);
    finish_acq("t5", 1, 8, 8'h80, 1'b0, -1, 1);

    // 6: reset in WAIT, then a fresh acquisition with new config
    ack_mode = 0;
    start_acq(2, 2, 8'h80, 1'b0);
    stim_q = '{8'h00, 8'h00, 8'h00};
    send_all();
    ack_mode = 2;
    @(negedge clk_i);
    chk("t6_pre_busy", {30'd0, busy_o, SI_rdy_o}, 32'd3);
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    acq_open = 0;
    chk("t6_rdy", {31'd0, SI_rdy_o}, 32'd0);
    chk("t6_trig", {31'd0, SI_trig_o}, 32'd0);
    chk("t6_data", {24'd0, SI_data_o}, 32'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_done", {31'd0, done_o}, 32'd0);
    ack_mode = 1;
    start_acq(3, 4, 8'h80, 1'b0);
    stim_q = '{8'h10, 8'hF0, 8'h20, 8'h30, 8'h50, 8'h90, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    send_all();
    finish_acq("t6", 3, 4, 8'h80, 1'b0, -1, 0);

    // Randomized acquisitions
    for (int r = 0; r < 8; r++) begin
      int pre  = $urandom_range(0, 4);
      int post = $urandom_range(0, 4);
      logic [DW-1:0] lvl = DW'($urandom);
      logic edg = 1'($urandom);
      ack_mode = $urandom_range(0, 1);
      start_acq(pre, post, lvl, edg);
      for (int i = 0; i < 20; i++) stim_q.push_back(DW'($urandom));
      send_all();
      finish_acq($sformatf("rnd%0d", r), pre, post, lvl, edg, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
